// File: rtl/boot_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream and writes them
// to consecutive memory addresses while holding the CPU halted; otherwise passes CPU through.
module boot_loader #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned START_ADDR = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_in,
  input  logic        cpu_mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_in,
  output logic        mem_mem_write,
  output logic        cpu_halt,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DAT_HI = 3'd3;
  localparam logic [2:0] DAT_LO = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [15:0] START16 = START_ADDR[15:0];
  localparam logic [31:0] DEPTH32 = DEPTH;
  localparam logic [31:0] START32 = START_ADDR;

  logic [2:0]  state_q, state_d;
  logic [15:0] length_q, length_d;
  logic [15:0] index_q, index_d;
  logic [15:0] word_q, word_d;
  logic [15:0] words_loaded_q, words_loaded_d;

  logic        accept;
  logic [15:0] len_n;
  logic [15:0] index_inc;
  logic [31:0] end_addr;

  assign rx_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DAT_HI) || (state_q == DAT_LO);
  assign cpu_halt  = rx_ready || (state_q == WRITE);
  assign accept    = rx_valid && rx_ready;
  assign len_n     = {length_q[15:8], rx_data};
  assign index_inc = index_q + 16'd1;
  // 32-bit sum so a huge length cannot wrap past the depth check
  assign end_addr  = START32 + {16'd0, len_n};

  always_comb begin
    state_d        = state_q;
    length_d       = length_q;
    index_d        = index_q;
    word_d         = word_q;
    words_loaded_d = words_loaded_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          words_loaded_d = 16'd0;
          index_d        = 16'd0;
          length_d       = 16'd0;
          state_d        = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          length_d = {rx_data, length_q[7:0]};
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          length_d = len_n;
          if (len_n == 16'd0)          state_d = DONE;
          else if (end_addr > DEPTH32) state_d = ERROR;
          else                         state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          word_d  = {rx_data, word_q[7:0]};
          state_d = DAT_LO;
        end
      end
      DAT_LO: begin
        if (accept) begin
          word_d  = {word_q[15:8], rx_data};
          state_d = WRITE;
        end
      end
      WRITE: begin
        index_d        = index_inc;
        words_loaded_d = words_loaded_q + 16'd1;
        state_d        = (index_inc == length_q) ? DONE : DAT_HI;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      length_q       <= 16'd0;
      index_q        <= 16'd0;
      word_q         <= 16'd0;
      words_loaded_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      length_q       <= length_d;
      index_q        <= index_d;
      word_q         <= word_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  // While halted the loader owns the memory port and CPU writes are dropped
  assign mem_address   = cpu_halt ? (START16 + index_q) : cpu_address;
  assign mem_data_in   = cpu_halt ? word_q : cpu_data_in;
  assign mem_mem_write = cpu_halt ? (state_q == WRITE) : cpu_mem_write;

  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: loader writes are checked against a scoreboard queue.
module tb_boot_loader;

  logic        clock, reset, load_start;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] cpu_address, cpu_data_in;
  logic        cpu_mem_write;
  logic [15:0] mem_address, mem_data_in;
  logic        mem_mem_write, cpu_halt, done, error;
  logic [15:0] words_loaded;

  logic        clk_en;
  int          n_vec;
  int          n_err;
  int          cyc_n;
  int          first_acc;
  logic        rdy_s;
  logic [31:0] sb[$];
  int          wr_cyc[$];

  boot_loader dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in), .cpu_mem_write(cpu_mem_write),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_mem_write(mem_mem_write),
    .cpu_halt(cpu_halt), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 if (clk_en) clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge, then advances to just after the next rising edge
  task automatic tick();
    logic [31:0] e;
    @(negedge clock);
    rdy_s = rx_ready;
    if (cpu_halt === 1'b1 && mem_mem_write === 1'b1) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL extra_write: observed addr %h data %h expected no write", mem_address, mem_data_in);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("loader_write", {mem_address, mem_data_in}, e);
      end
      wr_cyc.push_back(cyc_n);
    end
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic        acc;
    logic [15:0] wl;
    rx_valid = 1'b0;
    wl = words_loaded;
    for (int g = 0; g < gap; g++) begin
      tick();
      if (g == 0) wl = words_loaded;
    end
    if (gap >= 2) begin
      chk("gap_hold_ready", {31'd0, rx_ready}, 32'd1);
      chk("gap_hold_wl", {16'd0, words_loaded}, {16'd0, wl});
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      tick();
      acc = rdy_s;
    end
    chk("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes6 [6];
    bytes6 = '{8'h00, 8'h02, 8'h00, 8'h08, 8'h08, 8'h14};
    n_vec = 0; n_err = 0; cyc_n = 0;
    clock = 1'b0; clk_en = 1'b0; reset = 1'b1; load_start = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0;
    cpu_address = 16'h0023; cpu_data_in = 16'h5a5a; cpu_mem_write = 1'b0;

    // Asynchronous reset with the clock stopped
    #3 reset = 1'b0;
    #1;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_address}, 32'h0023);
    chk("rst_mem_data", {16'd0, mem_data_in}, 32'h5a5a);
    chk("rst_mem_we", {31'd0, mem_mem_write}, 32'd0);
    #2 reset = 1'b1;
    clk_en = 1'b1;
    @(posedge clock); #1;

    // Back-to-back load
    wr_cyc.delete();
    sb.push_back({16'd0, 16'h0008});
    sb.push_back({16'd1, 16'h0814});
    start_load();
    chk("b2b_halt_start", {31'd0, cpu_halt}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      send(bytes6[i], 0);
      if (i == 0) first_acc = cyc_n;
    end
    rx_valid = 1'b0;
    chk("b2b_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("b2b_done_lat", cyc_n - first_acc, 32'd7);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_halt_end", {31'd0, cpu_halt}, 32'd0);
    chk("b2b_words", {16'd0, words_loaded}, 32'd2);
    chk("b2b_nwrites", wr_cyc.size(), 32'd2);
    if (wr_cyc.size() == 2) chk("b2b_spacing", wr_cyc[1] - wr_cyc[0], 32'd3);
    repeat (4) tick();
    chk("b2b_done_11", {31'd0, done}, 32'd1);
    chk("b2b_words_11", {16'd0, words_loaded}, 32'd2);

    // Gapped stream
    wr_cyc.delete();
    sb.push_back({16'd0, 16'h0008});
    sb.push_back({16'd1, 16'h0814});
    start_load();
    chk("gap_words_clr", {16'd0, words_loaded}, 32'd0);
    for (int i = 0; i < 6; i++) send(bytes6[i], 2);
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_words", {16'd0, words_loaded}, 32'd2);
    chk("gap_nwrites", wr_cyc.size(), 32'd2);

    // Zero length
    start_load();
    send(8'h00, 0);
    send(8'h00, 0);
    rx_valid = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_words", {16'd0, words_loaded}, 32'd0);
    chk("zero_halt", {31'd0, cpu_halt}, 32'd0);
    repeat (2) tick();

    // Oversize length
    start_load();
    send(8'h02, 0);
    send(8'h01, 0);
    rx_valid = 1'b0;
    chk("over_error", {31'd0, error}, 32'd1);
    chk("over_done", {31'd0, done}, 32'd0);
    chk("over_ready", {31'd0, rx_ready}, 32'd0);
    chk("over_halt", {31'd0, cpu_halt}, 32'd0);
    repeat (2) tick();

    // Abort mid-load, then pass-through
    sb.push_back({16'd0, 16'haabb});
    start_load();
    chk("abort_error_clr", {31'd0, error}, 32'd0);
    send(8'h00, 0);
    send(8'h03, 0);
    send(8'haa, 0);
    send(8'hbb, 0);
    rx_valid = 1'b0;
    tick();
    chk("abort_words1", {16'd0, words_loaded}, 32'd1);
    cpu_address = 16'h00ff; cpu_mem_write = 1'b1;
    #1;
    chk("abort_cpu_blocked", {31'd0, mem_mem_write}, 32'd0);
    cpu_mem_write = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("abort_ls_halt", {31'd0, cpu_halt}, 32'd1);
    chk("abort_ls_ready", {31'd0, rx_ready}, 32'd1);
    chk("abort_ls_words", {16'd0, words_loaded}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_words0", {16'd0, words_loaded}, 32'd0);
    chk("abort_halt", {31'd0, cpu_halt}, 32'd0);
    chk("abort_ready", {31'd0, rx_ready}, 32'd0);
    cpu_address = 16'h0005; cpu_data_in = 16'h1234; cpu_mem_write = 1'b1;
    #1;
    chk("pass_we", {31'd0, mem_mem_write}, 32'd1);
    chk("pass_addr", {16'd0, mem_address}, 32'h0005);
    chk("pass_data", {16'd0, mem_data_in}, 32'h1234);
    cpu_mem_write = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();
    chk("abort_idle_halt", {31'd0, cpu_halt}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
